// File: rtl/sdram_wr_burst_ctrl.sv
// Purpose : drain the SDRAM write-path FIFO into fixed-length write bursts at a wrapping word address.
// Latency : fifo_rd_en -> word staged 1 cycle; sdram_wr_data_req -> sdram_wr_data 1 cycle.
// Backpr. : FIFO popped only when non-empty and a stage slot is free; the burst request is held until
//           sdram_wr_ack; beats are paced solely by sdram_wr_data_req.
//
// Ports:
//   clk, rst_n                  single clock (FIFO rd_clk domain), synchronous active-low reset
//   fifo_rd_en / fifo_rd_data   FIFO pop strobe; read data valid the cycle after the pop
//   fifo_empty                  FIFO empty flag
//   flush                       level; issue a partial burst of whatever is staged
//   sdram_wr_req/ack            burst request (held) / single-cycle accept
//   sdram_wr_addr/len           burst start word address and length, stable while requesting
//   sdram_wr_data_req/data      per-beat pull strobe / registered beat data
//   burst_done                  one-cycle pulse on the cycle the last beat is valid
//   busy                        controller is not idle
module sdram_wr_burst_ctrl #(
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned END_ADDR  = 24'h100000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              fifo_rd_en,
  input  logic [31:0]       fifo_rd_data,
  input  logic              fifo_empty,
  input  logic              flush,
  output logic              sdram_wr_req,
  input  logic              sdram_wr_ack,
  output logic [ADDR_W-1:0] sdram_wr_addr,
  output logic [3:0]        sdram_wr_len,
  input  logic              sdram_wr_data_req,
  output logic [31:0]       sdram_wr_data,
  output logic              burst_done,
  output logic              busy
);

  // Stage index width; at least one bit so a 1-word burst still has a legal index.
  localparam int unsigned LP_IW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned LP_DEPTH = 1 << LP_IW;

  localparam logic [3:0]        LP_BL   = 4'(BURST_LEN);
  localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LP_END  = (ADDR_W+1)'(END_ADDR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_REQ,
    S_XFER
  } state_t;

  state_t            r_state;
  logic [3:0]        r_staged;   // words captured into the stage buffer
  logic [3:0]        r_issued;   // FIFO pops issued for this burst
  logic [3:0]        r_beat;     // beats already driven to the engine
  logic [3:0]        r_len;
  logic              r_rd_pend;  // a pop was issued last cycle; its data arrives now
  logic [ADDR_W-1:0] r_addr;
  logic              r_req;
  logic              r_done;
  logic [31:0]       r_data;
  logic [31:0]       r_stage [LP_DEPTH];

  logic              w_full;
  logic              w_flush_go;
  logic              w_rd_en;
  logic [ADDR_W:0]   w_addr_sum;

  assign w_full = (r_staged == LP_BL);

  // A flush is taken only with no read in flight (staged==issued), so no popped
  // word can be lost when leaving FILL. A full buffer takes priority.
  assign w_flush_go = flush && (r_staged != 4'd0) && (r_staged == r_issued) && !w_full;

  // The pop strobe is decoded from the live empty flag rather than registered:
  // a registered strobe would act on a stale flag and could pop an empty FIFO.
  // It is also suppressed on the flush cycle so nothing is popped as FILL is left.
  assign w_rd_en = (r_state == S_FILL) && !fifo_empty && (r_issued < LP_BL) && !w_flush_go;

  // Wrap check on the full ADDR_W+1-bit sum, before truncation.
  assign w_addr_sum = {1'b0, r_addr} + (ADDR_W+1)'(r_len);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_staged  <= 4'd0;
      r_issued  <= 4'd0;
      r_beat    <= 4'd0;
      r_len     <= 4'd0;
      r_rd_pend <= 1'b0;
      r_addr    <= LP_BASE;
      r_req     <= 1'b0;
      r_done    <= 1'b0;
      r_data    <= 32'd0;
    end else begin
      r_done    <= 1'b0;
      r_rd_pend <= w_rd_en;
      case (r_state)
        S_IDLE: begin
          if (!fifo_empty) begin
            r_state <= S_FILL;
          end
        end

        S_FILL: begin
          if (w_rd_en) begin
            r_issued <= r_issued + 4'd1;
          end
          if (r_rd_pend) begin
            r_staged <= r_staged + 4'd1;
          end
          if (w_full) begin
            r_len   <= LP_BL;
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end else if (w_flush_go) begin
            r_len   <= r_staged;
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end
        end

        S_REQ: begin
          if (sdram_wr_ack) begin
            r_req   <= 1'b0;
            r_beat  <= 4'd0;
            r_state <= S_XFER;
          end
        end

        S_XFER: begin
          if (sdram_wr_data_req && (r_beat < r_len)) begin
            r_data <= r_stage[r_beat[LP_IW-1:0]];
            r_beat <= r_beat + 4'd1;
            if ((r_beat + 4'd1) == r_len) begin
              // Last beat: close the burst and advance the address by the
              // actual length; a straddling burst wraps only after it is sent.
              r_done   <= 1'b1;
              r_staged <= 4'd0;
              r_issued <= 4'd0;
              r_state  <= S_IDLE;
              if (w_addr_sum >= LP_END) begin
                r_addr <= LP_BASE;
              end else begin
                r_addr <= w_addr_sum[ADDR_W-1:0];
              end
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stage buffer holds payload only; it needs no reset because r_staged
  // gates what is ever read back out.
  always_ff @(posedge clk) begin
    if (r_rd_pend) begin
      r_stage[r_staged[LP_IW-1:0]] <= fifo_rd_data;
    end
  end

  assign fifo_rd_en    = w_rd_en;
  assign sdram_wr_req  = r_req;
  assign sdram_wr_addr = r_addr;
  assign sdram_wr_len  = r_len;
  assign sdram_wr_data = r_data;
  assign burst_done    = r_done;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_sdram_wr_burst_ctrl.sv
// Bench for sdram_wr_burst_ctrl with a 16-word address window so wrap and straddle are reachable.
module tb_sdram_wr_burst_ctrl;

  localparam int END_A = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data = 32'd0;
  logic        fifo_empty = 1'b1;
  logic        flush = 1'b0;
  logic        sdram_wr_req;
  logic        sdram_wr_ack = 1'b0;
  logic [23:0] sdram_wr_addr;
  logic [3:0]  sdram_wr_len;
  logic        sdram_wr_data_req = 1'b0;
  logic [31:0] sdram_wr_data;
  logic        burst_done;
  logic        busy;

  always #5 clk = ~clk;

  sdram_wr_burst_ctrl #(
    .BURST_LEN(8),
    .ADDR_W   (24),
    .BASE_ADDR(0),
    .END_ADDR (END_A)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fifo_rd_en       (fifo_rd_en),
    .fifo_rd_data     (fifo_rd_data),
    .fifo_empty       (fifo_empty),
    .flush            (flush),
    .sdram_wr_req     (sdram_wr_req),
    .sdram_wr_ack     (sdram_wr_ack),
    .sdram_wr_addr    (sdram_wr_addr),
    .sdram_wr_len     (sdram_wr_len),
    .sdram_wr_data_req(sdram_wr_data_req),
    .sdram_wr_data    (sdram_wr_data),
    .burst_done       (burst_done),
    .busy             (busy)
  );

  int          n_tests = 0;
  int          n_fail  = 0;

  // FIFO model: write pointer owned by the stimulus, read pointer by the pop process.
  logic [31:0] mem [1024];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          rd_cnt = 0;
  int          viol   = 0;
  bit          tog_en = 1'b0;
  bit          tog_ph = 1'b0;

  logic [31:0] exp_q [$];
  logic [23:0] exp_addr = 24'd0;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_cnt++;
      if (fifo_empty || (rd_ptr == wr_ptr)) begin
        viol++;
      end else begin
        fifo_rd_data <= mem[rd_ptr % 1024];
        rd_ptr++;
      end
    end
  end

  always @(negedge clk) begin
    tog_ph     = ~tog_ph;
    fifo_empty = (rd_ptr == wr_ptr) || (tog_en && tog_ph);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr % 1024] = base + 32'(i);
      wr_ptr++;
      exp_q.push_back(base + 32'(i));
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    flush = 1'b0;
    sdram_wr_ack = 1'b0;
    sdram_wr_data_req = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    exp_q.delete();
    exp_addr = 24'd0;
  endtask

  // Engine model for one burst: wait for the request, check addr/len, ack,
  // then pull len+extra beats and compare against the scoreboard.
  task automatic run_burst(input int len, input int extra);
    int          w;
    int          r0;
    int          s;
    logic [31:0] e;
    logic [31:0] last;
    w = 0;
    last = 32'd0;
    while (!sdram_wr_req && w < 200) begin
      cyc(1);
      w++;
    end
    n_tests++;
    if (!sdram_wr_req) begin
      n_fail++;
      $display("FAIL req_timeout: sdram_wr_req=%0b after %0d cycles, required 1", sdram_wr_req, w);
      return;
    end
    n_tests++;
    if (sdram_wr_addr !== exp_addr) begin
      n_fail++;
      $display("FAIL req_addr: got 0x%06h, required 0x%06h", sdram_wr_addr, exp_addr);
    end
    n_tests++;
    if (sdram_wr_len !== 4'(len)) begin
      n_fail++;
      $display("FAIL req_len: got %0d, required %0d", sdram_wr_len, len);
    end
    sdram_wr_ack = 1'b1;
    cyc(1);
    sdram_wr_ack = 1'b0;
    n_tests++;
    if (sdram_wr_req !== 1'b0) begin
      n_fail++;
      $display("FAIL req_drop: sdram_wr_req=%0b after ack, required 0", sdram_wr_req);
    end
    r0 = rd_cnt;
    for (int i = 0; i < len + extra; i++) begin
      sdram_wr_data_req = 1'b1;
      cyc(1);
      if (i < len) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_%0d: got 0x%08h, scoreboard empty", i, sdram_wr_data);
        end else begin
          e = exp_q.pop_front();
          last = e;
          if (sdram_wr_data !== e) begin
            n_fail++;
            $display("FAIL beat_%0d: got 0x%08h, required 0x%08h", i, sdram_wr_data, e);
          end
        end
        n_tests++;
        if (burst_done !== (i == len - 1)) begin
          n_fail++;
          $display("FAIL done_beat_%0d: got %0b, required %0b", i, burst_done, (i == len - 1));
        end
      end else begin
        n_tests++;
        if (sdram_wr_data !== last || burst_done !== 1'b0) begin
          n_fail++;
          $display("FAIL extra_req_%0d: data 0x%08h done %0b, required 0x%08h done 0", i, sdram_wr_data, burst_done, last);
        end
      end
    end
    sdram_wr_data_req = 1'b0;
    if (extra > 0) begin
      n_tests++;
      if (rd_cnt != r0) begin
        n_fail++;
        $display("FAIL extra_pops: %0d pops during transfer, required 0", rd_cnt - r0);
      end
    end
    s = int'(exp_addr) + len;
    exp_addr = (s >= END_A) ? 24'd0 : 24'(s);
    n_tests++;
    if (sdram_wr_addr !== exp_addr) begin
      n_fail++;
      $display("FAIL next_addr: got 0x%06h, required 0x%06h", sdram_wr_addr, exp_addr);
    end
    cyc(1);
    n_tests++;
    if (burst_done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_width: burst_done=%0b one cycle after last beat, required 0", burst_done);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cyc(2);
    n_tests++;
    if (fifo_rd_en !== 1'b0 || sdram_wr_req !== 1'b0 || burst_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: rd_en %0b req %0b done %0b busy %0b, required all 0",
               fifo_rd_en, sdram_wr_req, burst_done, busy);
    end
    n_tests++;
    if (sdram_wr_addr !== 24'd0 || sdram_wr_len !== 4'd0 || sdram_wr_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_dat: addr 0x%06h len %0d data 0x%08h, required 0/0/0",
               sdram_wr_addr, sdram_wr_len, sdram_wr_data);
    end
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_full_burst;
    int r0;
    do_reset();
    r0 = rd_cnt;
    push_words(32'h1, 8);
    run_burst(8, 0);
    n_tests++;
    if (rd_cnt - r0 != 8) begin
      n_fail++;
      $display("FAIL full_pops: got %0d pops, required 8", rd_cnt - r0);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_idle: busy=%0b after burst, required 0", busy);
    end
  endtask

  task automatic test_flush_straddle;
    do_reset();
    push_words(32'h31, 3);
    cyc(10);
    n_tests++;
    if (sdram_wr_req !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_hold: req %0b busy %0b before flush, required 0/1", sdram_wr_req, busy);
    end
    flush = 1'b1;
    run_burst(3, 0);
    flush = 1'b0;
    // Full bursts from 3: 3 -> 11, then 11+8 crosses the window end and wraps.
    push_words(32'h41, 8);
    run_burst(8, 0);
    push_words(32'h51, 8);
    run_burst(8, 0);
  endtask

  task automatic test_wrap;
    do_reset();
    push_words(32'h100, 8);
    run_burst(8, 0);
    push_words(32'h200, 8);
    run_burst(8, 0);
    push_words(32'h300, 8);
    run_burst(8, 0);
  endtask

  task automatic test_empty_toggle;
    int v0;
    v0 = viol;
    tog_en = 1'b1;
    push_words(32'hA0, 8);
    run_burst(8, 0);
    tog_en = 1'b0;
    n_tests++;
    if (viol != v0) begin
      n_fail++;
      $display("FAIL empty_pop: %0d pops while empty, required 0", viol - v0);
    end
  endtask

  task automatic test_reset_mid_xfer;
    int          w;
    logic [31:0] e;
    do_reset();
    push_words(32'h500, 8);
    w = 0;
    while (!sdram_wr_req && w < 200) begin
      cyc(1);
      w++;
    end
    sdram_wr_ack = 1'b1;
    cyc(1);
    sdram_wr_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sdram_wr_data_req = 1'b1;
      cyc(1);
      e = exp_q.pop_front();
      n_tests++;
      if (sdram_wr_data !== e) begin
        n_fail++;
        $display("FAIL mid_beat_%0d: got 0x%08h, required 0x%08h", i, sdram_wr_data, e);
      end
    end
    rst_n = 1'b0;
    cyc(1);
    sdram_wr_data_req = 1'b0;
    n_tests++;
    if (fifo_rd_en !== 1'b0 || sdram_wr_req !== 1'b0 || burst_done !== 1'b0 || busy !== 1'b0 ||
        sdram_wr_addr !== 24'd0 || sdram_wr_len !== 4'd0 || sdram_wr_data !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset: rd_en %0b req %0b done %0b busy %0b addr 0x%06h len %0d data 0x%08h, required all 0",
               fifo_rd_en, sdram_wr_req, burst_done, busy, sdram_wr_addr, sdram_wr_len, sdram_wr_data);
    end
    rst_n = 1'b1;
    exp_q.delete();
    exp_addr = 24'd0;
    push_words(32'h600, 8);
    run_burst(8, 0);
  endtask

  task automatic test_long_req;
    push_words(32'h700, 8);
    run_burst(8, 4);
    // Stray ack while idle must not start anything.
    sdram_wr_ack = 1'b1;
    cyc(1);
    sdram_wr_ack = 1'b0;
    cyc(1);
    n_tests++;
    if (sdram_wr_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_ack: req %0b busy %0b, required 0/0", sdram_wr_req, busy);
    end
  endtask

  task automatic test_back_to_back;
    push_words(32'h800, 16);
    run_burst(8, 0);
    run_burst(8, 0);
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_flush_straddle();
    test_wrap();
    test_empty_toggle();
    test_reset_mid_xfer();
    test_long_req();
    test_back_to_back();
    n_tests++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL pop_while_empty_total: %0d, required 0", viol);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
